qif_neuron_scheduler: RTL and testbench

//  Time-multiplexes one 8-bit QIF (quadratic integrate-and-fire) update datapath across N virtual

---
 rtl/qif_neuron_scheduler_if.sv | 26 ++
 rtl/qif_neuron_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_qif_neuron_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qif_neuron_scheduler_if.sv
// Datapath request/result channel between the QIF neuron scheduler and the
// 8-bit QIF arithmetic core.
//   dp_valid / dp_ready : request handshake, accepted when both are high
//   dp_v, dp_i          : membrane value and input current of the issued neuron
//   dp_done             : one-cycle result strobe from the core
//   dp_v_next, dp_spike : result, valid together with dp_done
// master = scheduler side, slave = arithmetic core side.
interface qif_neuron_scheduler_if;
    logic       dp_valid;
    logic       dp_ready;
    logic [7:0] dp_v;
    logic [7:0] dp_i;
    logic       dp_done;
    logic [7:0] dp_v_next;
    logic       dp_spike;

    modport master (
        output dp_valid, dp_v, dp_i,
        input  dp_ready, dp_done, dp_v_next, dp_spike
    );

    modport slave (
        input  dp_valid, dp_v, dp_i,
        output dp_ready, dp_done, dp_v_next, dp_spike
    );
endinterface

// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexes one 8-bit QIF update datapath across N_NEURONS virtual neurons.
// Each tick_start runs one sweep k = 0..N_NEURONS-1: issue (v[k], i[k]) to the
// datapath, wait for the result (bounded by WAIT_TIMEOUT cycles), write it back
// and record the spike. No arithmetic here; values are stored and forwarded.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 low freezes all state and outputs
//   tick_start          one-cycle pulse starting a sweep (ignored unless idle)
//   busy, sweep_done    sweep in progress / one-cycle end-of-sweep pulse
//   spike_out           spike flags of the last completed sweep
//   err_timeout         sticky datapath timeout flag
//   cfg_we/addr/data    input current write, accepted only while idle
//   dp                  datapath channel (master modport)
// Optional feature: define QIF_REFRACTORY_EN to skip a neuron for REFRAC_TICKS
// sweeps after it spikes.
module qif_neuron_scheduler #(
    parameter int unsigned N_NEURONS    = 4,
    parameter logic [7:0]  V_RESET      = 8'd0,
    parameter int unsigned WAIT_TIMEOUT = 15,
    parameter int unsigned REFRAC_TICKS = 2,
    localparam int unsigned AW          = $clog2(N_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   tick_start,
    output logic                   busy,
    output logic                   sweep_done,
    output logic [N_NEURONS-1:0]   spike_out,
    output logic                   err_timeout,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [7:0]             cfg_data,
    qif_neuron_scheduler_if.master dp
);

    if (N_NEURONS < 2 || N_NEURONS > 16 || WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255 ||
        REFRAC_TICKS < 1 || REFRAC_TICKS > 7) begin : g_bad_params
        $error("qif_neuron_scheduler: parameter out of range");
    end

    localparam logic [AW:0]   NCount   = (AW + 1)'(N_NEURONS);
    localparam logic [AW-1:0] LastK    = AW'(N_NEURONS - 1);
    localparam logic [7:0]    WaitLast = 8'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDone} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        k_q, k_d;
    logic [7:0]           v_q [N_NEURONS];
    logic [7:0]           v_d [N_NEURONS];
    logic [7:0]           i_q [N_NEURONS];
    logic [7:0]           i_d [N_NEURONS];
    logic [N_NEURONS-1:0] shadow_q, shadow_d;
    logic [N_NEURONS-1:0] spike_out_q, spike_out_d;
    logic                 err_q, err_d;
    logic [7:0]           wait_q, wait_d;
    logic [7:0]           res_v_q, res_v_d;   // result held from WAIT into WRITE
    logic                 res_spk_q, res_spk_d;
    logic                 skip;               // current neuron bypasses the datapath

`ifdef QIF_REFRACTORY_EN
    localparam logic [2:0] RefracInit = 3'(REFRAC_TICKS);
    logic [2:0] rc_q [N_NEURONS];
    logic [2:0] rc_d [N_NEURONS];
    assign skip = (rc_q[k_q] != 3'd0);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        v_d         = v_q;
        i_d         = i_q;
        shadow_d    = shadow_q;
        spike_out_d = spike_out_q;
        err_d       = err_q;
        wait_d      = wait_q;
        res_v_d     = res_v_q;
        res_spk_d   = res_spk_q;
`ifdef QIF_REFRACTORY_EN
        rc_d        = rc_q;
`endif
        // Write lands before the sweep's first ISSUE, so a write alongside
        // tick_start is seen by this sweep.
        if (state_q == StIdle && cfg_we && {1'b0, cfg_addr} < NCount) begin
            i_d[cfg_addr] = cfg_data;
        end
        unique case (state_q)
            StIdle: begin
                if (tick_start) begin
                    state_d = StIssue;
                    k_d     = '0;
                end
            end
            StIssue: begin
                if (skip) begin
`ifdef QIF_REFRACTORY_EN
                    rc_d[k_q] = rc_q[k_q] - 3'd1;
`endif
                    res_v_d   = V_RESET;
                    res_spk_d = 1'b0;
                    state_d   = StWrite;
                end else if (dp.dp_ready) begin
                    wait_d  = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dp.dp_done) begin
                    res_v_d   = dp.dp_v_next;
                    res_spk_d = dp.dp_spike;
                    state_d   = StWrite;
                end else if (wait_q == WaitLast) begin
                    res_v_d   = v_q[k_q];
                    res_spk_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = StWrite;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWrite: begin
                v_d[k_q]      = res_spk_q ? V_RESET : res_v_q;
                shadow_d[k_q] = res_spk_q;
`ifdef QIF_REFRACTORY_EN
                if (res_spk_q) begin
                    rc_d[k_q] = RefracInit;
                end
`endif
                if (k_q == LastK) begin
                    spike_out_d = shadow_d;
                    state_d     = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StIssue;
                end
            end
            StDone: begin
                k_d     = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            shadow_q    <= '0;
            spike_out_q <= '0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            res_v_q     <= '0;
            res_spk_q   <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                v_q[n] <= V_RESET;
                i_q[n] <= '0;
`ifdef QIF_REFRACTORY_EN
                rc_q[n] <= '0;
`endif
            end
        end else if (ena) begin
            state_q     <= state_d;
            k_q         <= k_d;
            v_q         <= v_d;
            i_q         <= i_d;
            shadow_q    <= shadow_d;
            spike_out_q <= spike_out_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            res_v_q     <= res_v_d;
            res_spk_q   <= res_spk_d;
`ifdef QIF_REFRACTORY_EN
            rc_q        <= rc_d;
`endif
        end
    end

    // Outputs decode registered state only, so they hold while ena is low.
    always_comb begin
        dp.dp_valid = 1'b0;
        dp.dp_v     = '0;
        dp.dp_i     = '0;
        if (state_q == StIssue) begin
            dp.dp_valid = !skip;
            dp.dp_v     = v_q[k_q];
            dp.dp_i     = i_q[k_q];
        end
    end

    assign busy        = (state_q != StIdle);
    assign sweep_done  = (state_q == StDone);
    assign spike_out   = spike_out_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Scoreboard bench for qif_neuron_scheduler. N = 5 so that addresses 5..7 are
// representable and exercise the out-of-range cfg drop. The reference model
// plays each sweep from per-neuron datapath plans and queues the expected
// accepts and sweep results; responder/monitor processes compare them.
`timescale 1ns/1ps
module tb_qif_neuron_scheduler;
    localparam int         N  = 5;
    localparam int         AW = $clog2(N);
    localparam logic [7:0] VR = 8'd0;
    localparam int         TO = 15;
    localparam int         RT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          tick_start = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [7:0]    cfg_data = '0;
    logic          busy, sweep_done, err_timeout;
    logic [N-1:0]  spike_out;

    qif_neuron_scheduler_if dp ();

    qif_neuron_scheduler #(
        .N_NEURONS   (N),
        .V_RESET     (VR),
        .WAIT_TIMEOUT(TO),
        .REFRAC_TICKS(RT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .tick_start (tick_start),
        .busy       (busy),
        .sweep_done (sweep_done),
        .spike_out  (spike_out),
        .err_timeout(err_timeout),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .dp         (dp.master)
    );

    always #5 clk = ~clk;

    typedef struct { int k; logic [7:0] v; logic [7:0] i; } acc_t;
    typedef struct { logic [N-1:0] spk; logic err; int lat; } swp_t;

    acc_t acc_q[$];
    swp_t swp_q[$];

    // Reference model state and per-neuron datapath plan (plan_d == 0: never answer)
    logic [7:0] v_m [N];
    logic [7:0] i_m [N];
    int         rc_m [N];
    logic       err_m;
    int         plan_r [N];
    int         plan_d [N];
    logic [7:0] plan_vn [N];
    logic       plan_spk [N];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tick_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Datapath responder and accept monitor
    int         pend = 0;
    int         rcnt = 0;
    int         rk = 0;
    logic [7:0] pvn = '0;
    logic       pspk = 1'b0;
    always @(negedge clk) begin
        dp.dp_done = 1'b0;
        if (!rst_n) begin
            pend = 0;
            rcnt = 0;
            dp.dp_ready = 1'b0;
            dp.dp_v_next = '0;
            dp.dp_spike = 1'b0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dp.dp_done = 1'b1;
                    dp.dp_v_next = pvn;
                    dp.dp_spike = pspk;
                end
            end
            if (dp.dp_valid) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_dp_valid", 1, 0);
                    dp.dp_ready = 1'b1;
                    pend = 1;
                end else begin
                    rk = acc_q[0].k;
                    check($sformatf("dp_v[k=%0d]", rk), dp.dp_v, acc_q[0].v);
                    check($sformatf("dp_i[k=%0d]", rk), dp.dp_i, acc_q[0].i);
                    if (rcnt >= plan_r[rk]) begin
                        dp.dp_ready = 1'b1;
                        rcnt = 0;
                        pend = plan_d[rk];
                        pvn = plan_vn[rk];
                        pspk = plan_spk[rk];
                        void'(acc_q.pop_front());
                    end else begin
                        dp.dp_ready = 1'b0;
                        rcnt++;
                        // Stray strobe during ISSUE must be ignored
                        if ($urandom_range(1, 0) == 1) begin
                            dp.dp_done = 1'b1;
                            dp.dp_spike = 1'b1;
                            dp.dp_v_next = 8'($urandom);
                        end
                    end
                end
            end else begin
                dp.dp_ready = 1'($urandom_range(1, 0));
                if (!busy && pend == 0 && $urandom_range(3, 0) == 0) begin
                    dp.dp_done = 1'b1;
                    dp.dp_spike = 1'b1;
                    dp.dp_v_next = 8'($urandom);
                end
            end
        end
    end

    // Sweep-result monitor
    logic saw_done = 1'b0;
    swp_t se;
    always @(negedge clk) begin
        if (rst_n && sweep_done) begin
            if (swp_q.size() == 0) begin
                check("unexpected_sweep_done", 1, 0);
            end else begin
                se = swp_q.pop_front();
                check("spike_out", spike_out, se.spk);
                check("err_timeout", err_timeout, se.err);
                check("sweep_latency", cyc - tick_cyc, se.lat);
                check("busy_in_done", busy, 1);
            end
            saw_done = 1'b1;
        end else if (saw_done) begin
            check("sweep_done_one_cycle", sweep_done, 0);
            check("busy_after_done", busy, 0);
            saw_done = 1'b0;
        end
    end

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            v_m[n] = VR;
            i_m[n] = '0;
            rc_m[n] = 0;
        end
        err_m = 1'b0;
    endtask

    task automatic set_ideal();
        for (int n = 0; n < N; n++) begin
            plan_r[n] = 0;
            plan_d[n] = 1;
            plan_vn[n] = 8'($urandom);
            plan_spk[n] = 1'b0;
        end
    endtask

    task automatic set_random();
        for (int n = 0; n < N; n++) begin
            plan_r[n] = $urandom_range(3, 0);
            plan_d[n] = ($urandom_range(15, 0) == 0) ? 0 : $urandom_range(4, 1);
            plan_vn[n] = 8'($urandom);
            plan_spk[n] = ($urandom_range(3, 0) == 0);
        end
    endtask

    // Plays one sweep in the model: queue expected accepts and the sweep result.
    task automatic model_sweep();
        swp_t e;
        int lat = 0;
        logic [N-1:0] spk = '0;
        for (int n = 0; n < N; n++) begin
`ifdef QIF_REFRACTORY_EN
            if (rc_m[n] != 0) begin
                rc_m[n]--;
                v_m[n] = VR;
                lat += 2;
                continue;
            end
`endif
            acc_q.push_back('{n, v_m[n], i_m[n]});
            lat += 2 + plan_r[n];
            if (plan_d[n] == 0) begin
                lat += TO;
                err_m = 1'b1;
            end else begin
                lat += plan_d[n];
                if (plan_spk[n]) begin
                    v_m[n] = VR;
                    spk[n] = 1'b1;
                    rc_m[n] = RT;
                end else begin
                    v_m[n] = plan_vn[n];
                end
            end
        end
        e.spk = spk;
        e.err = err_m;
        e.lat = lat;
        swp_q.push_back(e);
    endtask

    task automatic cfg_write(input int a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = d;
        if (a < N) i_m[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!sweep_done && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!sweep_done) check("sweep_done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic start_tick(input bit tcfg, input int ca, input logic [7:0] cd);
        @(negedge clk);
        tick_start = 1'b1;
        if (tcfg) begin
            cfg_we = 1'b1;
            cfg_addr = AW'(ca);
            cfg_data = cd;
        end
        @(posedge clk);
        #1 tick_cyc = cyc;
        @(negedge clk);
        tick_start = 1'b0;
        cfg_we = 1'b0;
    endtask

    // Writes and ticks while busy; none of them may take effect.
    task automatic busy_noise();
        for (int c = 0; c < 6; c++) begin
            cfg_we = 1'b1;
            cfg_addr = (c == 0) ? AW'(1) : AW'($urandom_range(N - 1, 0));
            cfg_data = (c == 0) ? 8'd99 : 8'($urandom);
            tick_start = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        cfg_we = 1'b0;
        tick_start = 1'b0;
    endtask

    task automatic run_sweep(input bit tcfg, input int ca, input logic [7:0] cd, input bit noise);
        if (tcfg && ca < N) i_m[ca] = cd;
        model_sweep();
        start_tick(tcfg, ca, cd);
        if (noise) busy_noise();
        wait_done();
    endtask

    task automatic check_reset();
        check("rst_busy", busy, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_spike_out", spike_out, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_dp_valid", dp.dp_valid, 0);
        check("rst_dp_v", dp.dp_v, 0);
        check("rst_dp_i", dp.dp_i, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        set_ideal();
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        // Basic sweep with distinct currents, ideal datapath
        for (int n = 0; n < N; n++) cfg_write(n, 8'(10 * (n + 1)));
        set_ideal();
        run_sweep(0, 0, 8'd0, 0);

        // Spike on k=2, ready stall on k=1, writes/ticks while busy
        set_ideal();
        plan_spk[2] = 1'b1;
        plan_r[1] = 5;
        run_sweep(0, 0, 8'd0, 1);

        // Datapath never answers k=3
        set_ideal();
        plan_d[3] = 0;
        run_sweep(0, 0, 8'd0, 0);

        // Out-of-range writes dropped, in-range write accepted
        cfg_write(5, 8'd77);
        cfg_write(7, 8'd1);
        cfg_write(1, 8'd123);

        // ena low: tick and write ignored
        @(negedge clk);
        ena = 1'b0;
        tick_start = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_data = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("ena_low_busy", busy, 0);
        end
        ena = 1'b1;
        tick_start = 1'b0;
        cfg_we = 1'b0;

        // Write coinciding with tick is used by that sweep
        set_ideal();
        run_sweep(1, 4, 8'd200, 0);

        // Spike on k=0 then several sweeps (refractory skip when enabled)
        set_ideal();
        plan_spk[0] = 1'b1;
        run_sweep(0, 0, 8'd0, 0);
        for (int s = 0; s < 3; s++) begin
            set_ideal();
            run_sweep(0, 0, 8'd0, 0);
        end

        // Randomized sweeps
        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(1, 0) == 1) cfg_write($urandom_range(7, 0), 8'($urandom));
            set_random();
            run_sweep($urandom_range(3, 0) == 0, $urandom_range(7, 0), 8'($urandom),
                      $urandom_range(1, 0) == 1);
        end

        // Reset in the middle of a sweep discards it
        set_ideal();
        model_sweep();
        start_tick(0, 0, 8'd0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        acc_q.delete();
        swp_q.delete();
        model_reset();
        #1 check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_ideal();
        run_sweep(0, 0, 8'd0, 0);

        check("acc_queue_drained", acc_q.size(), 0);
        check("sweep_queue_drained", swp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
